bus_channel_arbiter: RTL and testbench
======================================

// Module: bus_channel_arbiter
// PURPOSE
//  Shares one request/response bus channel (write or read) between N_MASTERS masters.
//  Sits between the masters and the single master-side port of the address-decoding
//  interconnect; instantiated once for the write channel and once for the read channel.
//  - Arbitration: round-robin.
//  - Grant is locked until the slave responds.
//  - A timeout returns an error response when no slave answers.
// PARAMETERS
//  N_MASTERS  2   number of requesting masters (>=2)
//  AW         8   address width
//  DW         32  data width (write data and read data)
//  IW         4   transaction id width
//  TIMEOUT    16  cycles in BUSY before error completion; 0 disables the timeout
// PORTS
//  clk          in   1            clock, all state on rising edge
//  rst          in   1            asynchronous, active-high reset
//  m_valid      in   N_MASTERS    per-master request valid, held until m_ready
//  m_addr       in   N_MASTERS*AW per-master address, master i in bits [i*AW +: AW]
//  m_wdata      in   N_MASTERS*DW per-master write data (tie 0 on the read channel)
//  m_id         in   N_MASTERS*IW per-master transaction id
//  m_ready      out  N_MASTERS    per-master completion pulse
//  m_resp       out  N_MASTERS*2  per-master response code, valid with m_ready
//  m_rdata      out  N_MASTERS*DW per-master read data, valid with m_ready
//  s_valid      out  1            request valid toward interconnect
//  s_addr       out  AW           granted master's address
//  s_wdata      out  DW           granted master's write data
//  s_id         out  IW           granted master's id
//  s_ready      in   1            completion from interconnect
//  s_resp       in   2            response code from interconnect
//  s_rdata      in   DW           read data from interconnect
//  grant        out  N_MASTERS    one-hot current grant; 0 when idle
//  busy         out  1            1 when state != IDLE
//  timeout_err  out  1            1-cycle pulse when a timeout completion is issued
// BEHAVIOUR
//  Reset (asynchronous, rst=1):
//   - state=IDLE, rr_ptr=0, grant=0, timeout counter=0.
//   - All outputs 0.
//  State IDLE:
//   - If any m_valid, pick the first requester at or after rr_ptr (wrapping modulo N).
//   - Register it as the grant and go to BUSY on the next edge.
//   - Latency: 1 cycle from m_valid to s_valid. Nothing is driven downstream in IDLE.
//  State BUSY (granted master g):
//   - s_valid = m_valid[g]; s_addr, s_wdata and s_id are combinational copies of master g's fields.
//   - m_ready[g], m_resp[g] and m_rdata[g] are combinational copies of s_ready, s_resp and s_rdata.
//   - For all other masters i != g: m_ready[i]=0, m_resp[i]=0, m_rdata[i]=0.
//   - On s_ready=1: go to IDLE and set rr_ptr = (g+1) mod N.
//   - If m_valid[g] drops before s_ready (protocol abort): go to IDLE, rr_ptr = (g+1) mod N, no response.
//   - If TIMEOUT!=0: the counter increments each BUSY cycle without s_ready.
//     When it reaches TIMEOUT-1 with s_ready=0, go to ERR.
//   - If s_ready and the timeout terminal count occur in the same cycle, s_ready wins (normal completion).
//  State ERR (exactly 1 cycle):
//   - s_valid=0; m_ready[g]=1, m_resp[g]=2'b10, m_rdata[g]=0, timeout_err=1.
//   - Then go to IDLE with rr_ptr = (g+1) mod N.
//  General rules:
//   - There is always at least one IDLE cycle between consecutive grants.
//   - A master that is not granted sees m_ready=0 regardless of its m_valid.
//   - Pointer wrap: g = N-1 gives rr_ptr = 0.
//   - The timeout counter is wide enough for TIMEOUT-1 and clears whenever the block leaves BUSY.
//   - rst asserted mid-transaction: grant drops immediately and no response is issued.
//     A master must re-request after reset.
//   - s_resp values pass through unmodified, including slave error codes.
// TESTING
//  1. Single master:
//     m0 req addr=8'h10, wdata=32'hA5, id=3; slave s_ready at 2nd BUSY cycle with s_resp=0
//     -> s_valid 1 cycle after m_valid; m_ready[0] pulses with resp 0; grant returns to 0.
//  2. Contention:
//     m0 and m1 hold valid together from reset -> grant order m0, m1, m0, m1.
//     Each grant waits for its s_ready, with one IDLE cycle between grants.
//  3. Timeout:
//     TIMEOUT=4, m1 req addr=8'h50, s_ready held at 0
//     -> after 4 BUSY cycles, 1 ERR cycle: m_ready[1]=1, m_resp[1]=2'b10, timeout_err=1.
//     Next grant goes to m0 if it is requesting.
//  4. Race:
//     s_ready=1 on the same cycle the counter hits TIMEOUT-1
//     -> normal completion with s_resp, no timeout_err.
//  5. Read data routing:
//     m1 read with s_rdata=32'hDEADBEEF
//     -> m_rdata[1]=32'hDEADBEEF with m_ready[1]; m_rdata[0]=0 and m_ready[0]=0.
//  6. Reset mid-op:
//     rst asserted during BUSY -> grant, s_valid and busy go to 0 immediately.
//     After release, m0 has priority (rr_ptr=0).

Source files
------------

// File: rtl/bus_channel_arbiter.sv
// Round-robin arbiter sharing one request/response bus channel between N_MASTERS masters.
// The grant is held until the slave completes, the master aborts, or the timeout fires.
module bus_channel_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int AW        = 8,
   parameter int DW        = 32,
   parameter int IW        = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_MASTERS-1:0]    m_valid,
   input  logic [N_MASTERS*AW-1:0] m_addr,
   input  logic [N_MASTERS*DW-1:0] m_wdata,
   input  logic [N_MASTERS*IW-1:0] m_id,
   output logic [N_MASTERS-1:0]    m_ready,
   output logic [N_MASTERS*2-1:0]  m_resp,
   output logic [N_MASTERS*DW-1:0] m_rdata,
   output logic                    s_valid,
   output logic [AW-1:0]           s_addr,
   output logic [DW-1:0]           s_wdata,
   output logic [IW-1:0]           s_id,
   input  logic                    s_ready,
   input  logic [1:0]              s_resp,
   input  logic [DW-1:0]           s_rdata,
   output logic [N_MASTERS-1:0]    grant,
   output logic                    busy,
   output logic                    timeout_err
);

   localparam int IDXW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   state_t          state_q,   state_d;
   logic [IDXW-1:0] rr_ptr_q,  rr_ptr_d;
   logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
   logic [CW-1:0]   cnt_q,     cnt_d;

   logic            pick_found;
   logic [IDXW-1:0] pick_idx;
   logic [IDXW:0]   cand;
   logic [IDXW-1:0] next_ptr;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         gnt_idx_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         gnt_idx_q <= gnt_idx_d;
         cnt_q     <= cnt_d;
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 0; k < N_MASTERS; k++) begin
         cand = {1'b0, rr_ptr_q} + (IDXW+1)'(k);
         if (cand >= (IDXW+1)'(N_MASTERS)) begin
            cand = cand - (IDXW+1)'(N_MASTERS);
         end
         if (!pick_found && m_valid[cand[IDXW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IDXW-1:0];
         end
      end
   end

   assign next_ptr = (gnt_idx_q == IDXW'(N_MASTERS - 1)) ? '0 : gnt_idx_q + IDXW'(1);

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      gnt_idx_d = gnt_idx_q;
      cnt_d     = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               gnt_idx_d = pick_idx;
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // Completion outranks the timeout terminal count; an abort releases silently.
            if (s_ready || !m_valid[gnt_idx_q]) begin
               state_d  = ST_IDLE;
               rr_ptr_d = next_ptr;
               cnt_d    = '0;
            end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
               state_d = ST_ERR;
               cnt_d   = '0;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_ERR: begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr;
            cnt_d    = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      grant       = '0;
      busy        = (state_q != ST_IDLE);
      s_valid     = 1'b0;
      s_addr      = '0;
      s_wdata     = '0;
      s_id        = '0;
      m_ready     = '0;
      m_resp      = '0;
      m_rdata     = '0;
      timeout_err = 1'b0;
      case (state_q)
         ST_BUSY: begin
            grant[gnt_idx_q]              = 1'b1;
            s_valid                       = m_valid[gnt_idx_q];
            s_addr                        = m_addr[gnt_idx_q*AW +: AW];
            s_wdata                       = m_wdata[gnt_idx_q*DW +: DW];
            s_id                          = m_id[gnt_idx_q*IW +: IW];
            m_ready[gnt_idx_q]            = s_ready;
            m_resp[gnt_idx_q*2 +: 2]      = s_resp;
            m_rdata[gnt_idx_q*DW +: DW]   = s_rdata;
         end
         ST_ERR: begin
            grant[gnt_idx_q]              = 1'b1;
            m_ready[gnt_idx_q]            = 1'b1;
            m_resp[gnt_idx_q*2 +: 2]      = 2'b10;
            timeout_err                   = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_bus_channel_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, all compared against a
// transaction-level reference model of the arbiter kept in this file.
module tb_bus_channel_arbiter;

   localparam int N  = 3;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int IW = 4;
   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    m_valid;
   logic [N*AW-1:0] m_addr;
   logic [N*DW-1:0] m_wdata;
   logic [N*IW-1:0] m_id;
   logic [N-1:0]    m_ready;
   logic [2*N-1:0]  m_resp;
   logic [N*DW-1:0] m_rdata;
   logic            s_valid;
   logic [AW-1:0]   s_addr;
   logic [DW-1:0]   s_wdata;
   logic [IW-1:0]   s_id;
   logic            s_ready;
   logic [1:0]      s_resp;
   logic [DW-1:0]   s_rdata;
   logic [N-1:0]    grant;
   logic            busy;
   logic            timeout_err;

   always #5 clk = ~clk;

   bus_channel_arbiter #(
      .N_MASTERS(N), .AW(AW), .DW(DW), .IW(IW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_id(m_id),
      .m_ready(m_ready), .m_resp(m_resp), .m_rdata(m_rdata),
      .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_id(s_id),
      .s_ready(s_ready), .s_resp(s_resp), .s_rdata(s_rdata),
      .grant(grant), .busy(busy), .timeout_err(timeout_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: who owns the channel, how long it has waited, whose turn is next.
   int           owner;
   int           waited;
   int           rr;
   bit           in_err;
   logic [N-1:0] exp_ready;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      owner     = -1;
      waited    = 0;
      rr        = 0;
      in_err    = 1'b0;
      exp_ready = '0;
   endtask

   task automatic compare_all();
      logic [N-1:0]    e_grant;
      logic            e_busy;
      logic            e_sv;
      logic            e_terr;
      logic [AW-1:0]   e_addr;
      logic [DW-1:0]   e_wdata;
      logic [IW-1:0]   e_id;
      logic [N-1:0]    e_ready;
      logic [2*N-1:0]  e_resp;
      logic [N*DW-1:0] e_rdata;
      e_grant = '0; e_busy = 1'b0; e_sv = 1'b0; e_terr = 1'b0;
      e_addr = '0; e_wdata = '0; e_id = '0;
      e_ready = '0; e_resp = '0; e_rdata = '0;
      if (owner >= 0) begin
         e_grant[owner] = 1'b1;
         e_busy         = 1'b1;
         if (in_err) begin
            e_ready[owner]         = 1'b1;
            e_resp[2*owner +: 2]   = 2'b10;
            e_terr                 = 1'b1;
         end else begin
            e_sv                   = m_valid[owner];
            e_addr                 = m_addr[owner*AW +: AW];
            e_wdata                = m_wdata[owner*DW +: DW];
            e_id                   = m_id[owner*IW +: IW];
            e_ready[owner]         = s_ready;
            e_resp[2*owner +: 2]   = s_resp;
            e_rdata[owner*DW +: DW] = s_rdata;
         end
      end
      exp_ready = e_ready;
      check("grant",       128'(grant),       128'(e_grant));
      check("busy",        128'(busy),        128'(e_busy));
      check("s_valid",     128'(s_valid),     128'(e_sv));
      check("s_addr",      128'(s_addr),      128'(e_addr));
      check("s_wdata",     128'(s_wdata),     128'(e_wdata));
      check("s_id",        128'(s_id),        128'(e_id));
      check("m_ready",     128'(m_ready),     128'(e_ready));
      check("m_resp",      128'(m_resp),      128'(e_resp));
      check("m_rdata",     128'(m_rdata),     128'(e_rdata));
      check("timeout_err", 128'(timeout_err), 128'(e_terr));
   endtask

   task automatic model_step();
      if (owner < 0) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (rr + k) % N;
            if (m_valid[c]) begin
               owner = c;
               break;
            end
         end
         waited = 0;
      end else if (in_err) begin
         rr     = (owner + 1) % N;
         owner  = -1;
         in_err = 1'b0;
      end else if (s_ready || !m_valid[owner]) begin
         rr    = (owner + 1) % N;
         owner = -1;
      end else begin
         waited++;
         if (TO != 0 && waited == TO) in_err = 1'b1;
      end
   endtask

   task automatic sample();
      @(negedge clk);
      compare_all();
   endtask

   task automatic advance();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      sample();
      advance();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_valid = '0; m_addr = '0; m_wdata = '0; m_id = '0;
      s_ready = 1'b0; s_resp = '0; s_rdata = '0;
      model_reset();
      #1;
      compare_all();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drive_random();
      for (int i = 0; i < N; i++) begin
         if (m_valid[i]) begin
            if (exp_ready[i]) m_valid[i] = 1'b0;
            else if ($urandom_range(0, 39) == 0) m_valid[i] = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            m_valid[i]            = 1'b1;
            m_addr[i*AW +: AW]    = AW'($urandom);
            m_wdata[i*DW +: DW]   = DW'($urandom);
            m_id[i*IW +: IW]      = IW'($urandom);
         end
      end
      s_ready = ($urandom_range(0, 3) == 0);
      s_resp  = 2'($urandom);
      s_rdata = DW'($urandom);
   endtask

   logic [N-1:0] t2_q[$];
   logic [N-1:0] t2_exp[4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Single master transaction.
      do_reset();
      m_valid = 3'b001; m_addr[7:0] = 8'h10; m_wdata[31:0] = 32'hA5; m_id[3:0] = 4'd3;
      sample(); check("t1_idle_svalid", 128'(s_valid), 128'(0)); advance();
      sample();
      check("t1_svalid", 128'(s_valid), 128'(1));
      check("t1_saddr",  128'(s_addr),  128'(8'h10));
      check("t1_sid",    128'(s_id),    128'(4'd3));
      advance();
      s_ready = 1'b1; s_resp = 2'b00; s_rdata = 32'h0;
      sample();
      check("t1_ready", 128'(m_ready), 128'(3'b001));
      check("t1_resp",  128'(m_resp),  128'(0));
      advance();
      m_valid = '0; s_ready = 1'b0;
      sample(); check("t1_grant_idle", 128'(grant), 128'(0)); advance();

      // Contention between m0 and m1.
      do_reset();
      m_valid = 3'b011; s_ready = 1'b1;
      t2_exp = '{3'b001, 3'b010, 3'b001, 3'b010};
      t2_q.delete();
      for (int c = 0; c < 8; c++) begin
         sample();
         if (grant != '0) t2_q.push_back(grant);
         advance();
      end
      check("t2_ngrants", 128'(t2_q.size()), 128'(4));
      for (int i = 0; i < 4; i++) begin
         check("t2_order", 128'((i < t2_q.size()) ? t2_q[i] : 3'b000), 128'(t2_exp[i]));
      end

      // Timeout on m1, then m0 takes the next grant.
      do_reset();
      m_valid = 3'b010; m_addr[AW +: AW] = 8'h50; s_ready = 1'b0;
      repeat (5) cycle();
      m_valid[0] = 1'b1;
      sample();
      check("t3_ready", 128'(m_ready), 128'(3'b010));
      check("t3_resp",  128'(m_resp[3:2]), 128'(2'b10));
      check("t3_terr",  128'(timeout_err), 128'(1));
      check("t3_sval",  128'(s_valid), 128'(0));
      advance();
      m_valid[1] = 1'b0;
      cycle();
      sample(); check("t3_next_grant", 128'(grant), 128'(3'b001)); advance();
      s_ready = 1'b1;
      cycle();
      m_valid = '0; s_ready = 1'b0;
      cycle();

      // Completion on the timeout terminal-count cycle.
      do_reset();
      m_valid = 3'b001; s_ready = 1'b0;
      repeat (4) cycle();
      s_ready = 1'b1; s_resp = 2'b11; s_rdata = 32'h1234_5678;
      sample();
      check("t4_ready", 128'(m_ready), 128'(3'b001));
      check("t4_resp",  128'(m_resp[1:0]), 128'(2'b11));
      check("t4_terr",  128'(timeout_err), 128'(0));
      advance();
      m_valid = '0; s_ready = 1'b0;
      sample(); check("t4_idle", 128'(busy), 128'(0)); advance();

      // Read data routed only to the granted master.
      do_reset();
      m_valid = 3'b010;
      cycle();
      s_ready = 1'b1; s_resp = 2'b00; s_rdata = 32'hDEADBEEF;
      sample();
      check("t5_rdata1",  128'(m_rdata[63:32]), 128'(32'hDEADBEEF));
      check("t5_rdata0",  128'(m_rdata[31:0]),  128'(0));
      check("t5_ready0",  128'(m_ready[0]),     128'(0));
      check("t5_ready1",  128'(m_ready[1]),     128'(1));
      advance();
      m_valid = '0; s_ready = 1'b0;
      cycle();

      // Reset during BUSY drops everything at once; m0 wins afterwards.
      do_reset();
      m_valid = 3'b010;
      cycle();
      #1;
      check("t6_busy_before", 128'(busy), 128'(1));
      rst = 1'b1;
      #1;
      check("t6_grant", 128'(grant),   128'(0));
      check("t6_sval",  128'(s_valid), 128'(0));
      check("t6_busy",  128'(busy),    128'(0));
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_valid = 3'b011;
      cycle();
      sample(); check("t6_m0_first", 128'(grant), 128'(3'b001)); advance();

      // Random traffic with occasional asynchronous resets.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         drive_random();
         cycle();
         if (c % 997 == 500) begin
            rst = 1'b1;
            model_reset();
            #1;
            compare_all();
            @(posedge clk);
            #1;
            rst = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
